// File: rtl/timer_irq_if.sv
// Data-memory bus bundle between the MIPS core (master) and the interval timer (slave).
// Word-aligned byte addressing; reads and writes complete in the cycle presented.
interface timer_irq_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        MemRead;
  logic        MemWrite;

  modport master (
    output addr,
    output wdata,
    output MemRead,
    output MemWrite,
    input  rdata
  );

  modport slave (
    input  addr,
    input  wdata,
    input  MemRead,
    input  MemWrite,
    output rdata
  );
endinterface

// File: rtl/timer_irq.sv
// Memory-mapped auto-reload interval timer driving the core's external interrupt request.
// Optional prescaler compiled in with TIMER_PRESCALER_EN (PRESCALE clocks per tick).
module timer_irq #(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter int          PRESCALE  = 16
) (
  input  logic        clk,
  input  logic        reset,
  timer_irq_if.slave  bus,
  input  logic        irq_mask,
  output logic        IRQ
);

  logic [31:0] th_q, th_d;
  logic [31:0] tl_q, tl_d;
  logic        tim_en_q, tim_en_d;
  logic        irq_en_q, irq_en_d;
  logic        irq_status_q, irq_status_d;

  logic [29:0] base_word;
  logic [29:0] addr_word;
  logic        sel_th, sel_tl, sel_tcon;
  logic        wr_th, wr_tl, wr_tcon;
  logic        tick;
  logic        overflow;
  logic        unused_bits;

  // Byte-offset bits are don't-care; decode on word addresses only.
  assign base_word = BASE_ADDR[31:2];
  assign addr_word = bus.addr[31:2];
  assign sel_th    = (addr_word == base_word);
  assign sel_tl    = (addr_word == (base_word + 30'd1));
  assign sel_tcon  = (addr_word == (base_word + 30'd2));

  assign wr_th   = bus.MemWrite && sel_th;
  assign wr_tl   = bus.MemWrite && sel_tl;
  assign wr_tcon = bus.MemWrite && sel_tcon;

  assign unused_bits = ^{bus.addr[1:0], PRESCALE[0]};

`ifdef TIMER_PRESCALER_EN
  localparam logic [15:0] PRESCALE_MAX = 16'(PRESCALE - 1);

  logic [15:0] presc_q, presc_d;

  // A TCON write that stops the timer also restarts the prescale phase.
  always_comb begin
    presc_d = presc_q;
    if (wr_tcon && !bus.wdata[0]) begin
      presc_d = '0;
    end else if (tim_en_q) begin
      if (presc_q == PRESCALE_MAX) begin
        presc_d = '0;
      end else begin
        presc_d = presc_q + 16'd1;
      end
    end
  end

  assign tick = tim_en_q && (presc_q == PRESCALE_MAX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end
`else
  assign tick = tim_en_q;
`endif

  assign overflow = tick && (tl_q == 32'hFFFF_FFFF);

  // Bus writes beat a same-cycle tick; reload always uses the pre-edge TH.
  always_comb begin
    th_d         = th_q;
    tl_d         = tl_q;
    tim_en_d     = tim_en_q;
    irq_en_d     = irq_en_q;
    irq_status_d = irq_status_q;

    if (wr_th) begin
      th_d = bus.wdata;
    end

    if (wr_tl) begin
      tl_d = bus.wdata;
    end else if (tick) begin
      tl_d = overflow ? th_q : (tl_q + 32'd1);
    end

    if (wr_tcon) begin
      tim_en_d = bus.wdata[0];
      irq_en_d = bus.wdata[1];
      if (bus.wdata[2]) begin
        irq_status_d = 1'b0;
      end
    end

    if (overflow && irq_en_q) begin
      irq_status_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      th_q         <= '0;
      tl_q         <= '0;
      tim_en_q     <= 1'b0;
      irq_en_q     <= 1'b0;
      irq_status_q <= 1'b0;
    end else begin
      th_q         <= th_d;
      tl_q         <= tl_d;
      tim_en_q     <= tim_en_d;
      irq_en_q     <= irq_en_d;
      irq_status_q <= irq_status_d;
    end
  end

  always_comb begin
    bus.rdata = '0;
    if (bus.MemRead) begin
      if (sel_th) begin
        bus.rdata = th_q;
      end else if (sel_tl) begin
        bus.rdata = tl_q;
      end else if (sel_tcon) begin
        bus.rdata = {29'b0, irq_status_q, irq_en_q, tim_en_q};
      end
    end
  end

  // Masking only hides the request; the pending status survives kernel mode.
  assign IRQ = irq_status_q && irq_en_q && !irq_mask;

endmodule

// File: tb/tb_timer_irq.sv
// Scoreboard bench for timer_irq: expectations are queued as each bus read is driven
// and popped when the combinational read data and IRQ are sampled at the falling edge.
module tb_timer_irq;

  localparam logic [31:0] BASE = 32'h4000_0000;
`ifdef TIMER_PRESCALER_EN
  localparam int TICK_DIV = 4;
`else
  localparam int TICK_DIV = 1;
`endif

  logic clk;
  logic reset;
  logic irqMask;
  logic irq;

  int testsRun;
  int testsFailed;

  logic [31:0] expQ[$];
  string       tagQ[$];

  timer_irq_if busIf();

  timer_irq #(
    .BASE_ADDR(BASE),
    .PRESCALE (4)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (busIf),
    .irq_mask(irqMask),
    .IRQ     (irq)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic pushExpect(input string tag, input logic [31:0] value);
    tagQ.push_back(tag);
    expQ.push_back(value);
  endtask

  task automatic popCompare(input logic [31:0] observed);
    if (expQ.size() == 0) begin
      checkOutput("scoreboard_empty", observed, ~observed);
    end else begin
      checkOutput(tagQ.pop_front(), observed, expQ.pop_front());
    end
  endtask

  // One bus write; captured at the next rising edge, returns at edge+1.
  task automatic applyStimulus(input logic [3:0] off, input logic [31:0] data);
    busIf.addr     = BASE + {28'b0, off};
    busIf.wdata    = data;
    busIf.MemWrite = 1'b1;
    @(posedge clk);
    #1;
    busIf.MemWrite = 1'b0;
  endtask

  // One bus read cycle; checks read data and IRQ before the closing edge.
  task automatic readCheck(input logic [3:0] off, input logic [31:0] expData,
                           input logic expIrq, input string tag);
    busIf.addr    = BASE + {28'b0, off};
    busIf.MemRead = 1'b1;
    pushExpect({tag, "_rdata"}, expData);
    pushExpect({tag, "_irq"}, {31'b0, expIrq});
    @(negedge clk);
    popCompare(busIf.rdata);
    popCompare({31'b0, irq});
    @(posedge clk);
    #1;
    busIf.MemRead = 1'b0;
  endtask

  initial begin
    testsRun       = 0;
    testsFailed    = 0;
    reset          = 1'b0;
    irqMask        = 1'b0;
    busIf.addr     = '0;
    busIf.wdata    = '0;
    busIf.MemRead  = 1'b0;
    busIf.MemWrite = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;

    readCheck(4'd0, 32'h0, 1'b0, "rst_th");
    readCheck(4'd4, 32'h0, 1'b0, "rst_tl");
    readCheck(4'd8, 32'h0, 1'b0, "rst_tcon");

    applyStimulus(4'd0, 32'hFFFF_FFFD);
    applyStimulus(4'd4, 32'hFFFF_FFFD);
    applyStimulus(4'd8, 32'h3);
    readCheck(4'd4, 32'hFFFF_FFFD, 1'b0, "run_tl0");
    readCheck(4'd4, 32'hFFFF_FFFE, 1'b0, "run_tl1");
    readCheck(4'd4, 32'hFFFF_FFFF, 1'b0, "run_tl2");
    readCheck(4'd4, 32'hFFFF_FFFD, 1'b1, "reload_tl");
    readCheck(4'd8, 32'h7, 1'b1, "reload_tcon");

    applyStimulus(4'd8, 32'h7);
    readCheck(4'd8, 32'h7, 1'b1, "w1c_vs_set");

    applyStimulus(4'd8, 32'h7);
    readCheck(4'd8, 32'h3, 1'b0, "ack_tcon");
    readCheck(4'd4, 32'hFFFF_FFFD, 1'b1, "reirq_tl");

    irqMask = 1'b1;
    readCheck(4'd8, 32'h7, 1'b0, "masked");
    irqMask = 1'b0;
    readCheck(4'd8, 32'h7, 1'b1, "unmasked");

    applyStimulus(4'd4, 32'h0000_0010);
    readCheck(4'd4, 32'h0000_0010, 1'b1, "tl_wr_wins");
    readCheck(4'd4, 32'h0000_0011, 1'b1, "tl_after_wr");

    applyStimulus(4'd4, 32'hFFFF_FFFE);
    readCheck(4'd4, 32'hFFFF_FFFE, 1'b1, "tl_pre_reload");
    applyStimulus(4'd0, 32'h0000_0100);
    readCheck(4'd4, 32'hFFFF_FFFD, 1'b1, "reload_old_th");
    readCheck(4'd0, 32'h0000_0100, 1'b1, "th_new");

    applyStimulus(4'd8, 32'h1);
    readCheck(4'd4, 32'h0000_0100, 1'b0, "reload_new_th");
    readCheck(4'd8, 32'h5, 1'b0, "irq_en_off");

    applyStimulus(4'd8, 32'h4);
    readCheck(4'd8, 32'h0, 1'b0, "stopped_tcon");
    readCheck(4'd4, 32'h0000_0103, 1'b0, "frozen_tl0");
    readCheck(4'd4, 32'h0000_0103, 1'b0, "frozen_tl1");

    applyStimulus(4'd12, 32'hDEAD_BEEF);
    readCheck(4'd12, 32'h0, 1'b0, "unmapped_rd");
    readCheck(4'd0, 32'h0000_0100, 1'b0, "th_untouched");

    busIf.addr    = BASE + 32'd4;
    busIf.MemRead = 1'b0;
    pushExpect("no_read_strobe", 32'h0);
    @(negedge clk);
    popCompare(busIf.rdata);
    @(posedge clk);
    #1;

    applyStimulus(4'd4, 32'h0);
    applyStimulus(4'd8, 32'h1);
    for (int i = 0; i < 9; i++) begin
      readCheck(4'd4, 32'(i / TICK_DIV), 1'b0, $sformatf("tick_rate%0d", i));
    end

    applyStimulus(4'd8, 32'h0);
    applyStimulus(4'd0, 32'h0000_0055);
    applyStimulus(4'd4, 32'hFFFF_FFFF);
    applyStimulus(4'd8, 32'h3);
    repeat (TICK_DIV) begin
      @(posedge clk);
      #1;
    end
    readCheck(4'd4, 32'h0000_0055, 1'b1, "pre_reset_irq");

    // Asynchronous reset in the middle of a cycle must clear everything at once.
    busIf.addr    = BASE + 32'd4;
    busIf.MemRead = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    pushExpect("async_tl", 32'h0);
    pushExpect("async_irq", 32'h0);
    popCompare(busIf.rdata);
    popCompare({31'b0, irq});
    busIf.addr = BASE;
    #1;
    pushExpect("async_th", 32'h0);
    popCompare(busIf.rdata);
    busIf.addr = BASE + 32'd8;
    #1;
    pushExpect("async_tcon", 32'h0);
    popCompare(busIf.rdata);
    busIf.MemRead = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    readCheck(4'd4, 32'h0, 1'b0, "post_reset_tl");

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/timer_irq.md
# timer_irq

Memory-mapped interval timer for the pipelined MIPS core; sole source of the external interrupt consumed by the instruction decoder. Sits on the data-memory bus at 0x4000_0000–0x4000_0008 beside data RAM. Counts up with auto-reload from a period register and raises a level interrupt request until software acknowledges it.

## Interface
Parameters:
- BASE_ADDR, 32'h4000_0000, byte address of TH; TL at +4, TCON at +8
- PRESCALE, 16, clock cycles per count tick (only with prescaler compiled in; ≥1)

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-low; one clock, reset is asynchronous and active-low
- addr  input  32  bus byte address (bits [1:0] ignored)
- wdata  input  32  bus write data
- MemRead  input  1  bus read strobe
- MemWrite  input  1  bus write strobe
- irq_mask  input  1  high while the core runs in kernel mode (PC[31]=1); suppresses IRQ
- rdata  output  32  read data, combinational
- IRQ  output  1  interrupt request to the decoder

## Operation
- Registers: TH[31:0] reload value; TL[31:0] counter; TCON[2:0] = {irq_status, irq_en, tim_en}.
- Reset: TH=0, TL=0, TCON=0, prescale counter=0; rdata=0, IRQ=0.
- Tick: with tim_en=1, one tick per cycle (or per PRESCALE cycles, see Configuration). tim_en=0 freezes TL and prescale counter.
- On tick: if TL==32'hFFFF_FFFF then TL<=TH and, if irq_en=1, irq_status<=1; else TL<=TL+1 (32-bit, no saturation).
- IRQ = irq_status & irq_en & ~irq_mask (combinational). Masking does not clear irq_status.
- Writes (MemWrite, address match): TH<=wdata; TL<=wdata; TCON: tim_en<=wdata[0], irq_en<=wdata[1], irq_status cleared if wdata[2]=1 (write-1-to-clear, writing 0 leaves it).
- Reads (MemRead, address match): rdata = TH, TL, or {29'b0, TCON}; pre-edge values. No match or MemRead=0 -> rdata=0.
- Unmapped offsets inside the block (+12) ignored on write, read 0.
- Bus has no wait states; reads and writes complete in the cycle presented.

## Timing
- Write takes effect at the rising edge of the write cycle; readable next cycle.
- Write to TL in a tick cycle: write wins, no increment that cycle.
- Write to TH in a reload cycle: reload uses old TH.
- W1C of irq_status in the same cycle as a new overflow with irq_en=1: set wins, irq_status stays 1.
- Writing irq_en=0 drops IRQ the following cycle; irq_status retained.
- Overflow-to-IRQ latency: TL reloads and irq_status sets at the same edge; IRQ high immediately after that edge (same cycle TL shows TH).
- Period between overflows = (2^32 − TH) ticks.
- reset asserted mid-count: all state cleared immediately, IRQ low asynchronously.

## Configuration
- TIMER_PRESCALER_EN defined: 16-bit prescale counter counts 0..PRESCALE−1 while tim_en=1; tick issued when it equals PRESCALE−1, then wraps to 0. Writing TCON with tim_en=0 clears the prescale counter. PRESCALE=1 behaves as undefined.
- Not defined: tick every cycle tim_en=1; PRESCALE ignored; no prescale counter.

## Test plan
- Reset: assert reset, then read +0/+4/+8 -> 0,0,0; IRQ=0.
- Reload/IRQ: TH=FFFF_FFFD, TL=FFFF_FFFD, TCON=3 -> TL reads FFFF_FFFE, FFFF_FFFF, then FFFF_FFFD with IRQ=1 three ticks after enable; TCON reads 7.
- Acknowledge: with IRQ=1 write TCON=7 -> IRQ low next cycle, tim_en/irq_en stay 1; next overflow raises IRQ again 3 ticks later.
- Masking: irq_status=1, irq_mask=1 -> IRQ=0, TCON reads 7; drop irq_mask -> IRQ=1 same cycle.
- Collisions: W1C of TCON on overflow cycle -> irq_status stays 1; TL write of 0000_0010 on tick cycle -> TL reads 0000_0010, then 0000_0011.
- Prescaler (TIMER_PRESCALER_EN, PRESCALE=4): TL=0, TCON=1 -> TL increments once every 4 cycles; async reset mid-count -> all registers 0 immediately.
